// File: rtl/seq_det_pkg.sv
// Shared constants for the programmable serial pattern detector: reset
// configuration (drop-in for the old fixed 11011 detector) and MAX_LEN limits.
package seq_det_pkg;

  localparam int         SEQ_DET_MIN_MAX_LEN = 2;
  localparam int         SEQ_DET_MAX_MAX_LEN = 32;

  localparam logic [4:0] SEQ_DET_RST_PATTERN = 5'b11011;
  localparam int         SEQ_DET_RST_LEN     = 5;
  localparam logic       SEQ_DET_RST_OVL     = 1'b1;

  // A programmed length is usable only if it selects at least one history bit.
  function automatic logic len_legal(input int len, input int max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_det_param_sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment wins.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seq_det_param.sv
// Runtime-programmable serial pattern detector with optional overlap.
// in_valid qualifies in for one cycle; there is no backpressure, every qualified bit is consumed.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               in_valid,
  input  logic               in,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  input  logic               cnt_clr
);

  if (MAX_LEN < SEQ_DET_MIN_MAX_LEN || MAX_LEN > SEQ_DET_MAX_MAX_LEN) begin : g_bad_max_len
    $error("seq_det_param: MAX_LEN out of range");
  end

  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;

  logic [MAX_LEN-1:0] h_next;
  logic [LEN_W-1:0]   fill_next;
  logic [MAX_LEN-1:0] len_mask;
  logic               cfg_ok;
  logic               hit;

  // The oldest history bit is shifted out before it is ever compared.
  logic unused_hist_msb;
  assign unused_hist_msb = hist[MAX_LEN-1];

  always_comb begin
    h_next    = {hist[MAX_LEN-2:0], in};
    fill_next = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len));
    end
    cfg_ok = len_legal(int'(cfg_len), MAX_LEN);
    // Any config write, accepted or not, swallows the bit presented with it.
    hit    = in_valid && !cfg_we && (fill_next >= len) &&
             (((h_next ^ pat) & len_mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pat     <= MAX_LEN'(SEQ_DET_RST_PATTERN);
      len     <= LEN_W'(SEQ_DET_RST_LEN);
      ovl     <= SEQ_DET_RST_OVL;
      hist    <= '0;
      fill    <= '0;
      match   <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      match   <= hit;
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_we) begin
        if (cfg_ok) begin
          pat  <= cfg_pattern;
          len  <= cfg_len;
          ovl  <= cfg_overlap;
          hist <= '0;
          fill <= '0;
        end
      end else if (in_valid) begin
        hist <= h_next;
        // Non-overlapping mode forgets the matched bits by emptying the window.
        fill <= (hit && !ovl) ? '0 : fill_next;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (hit),
    .count(match_cnt)
  );

endmodule
